// File: rtl/sha3_digest_unloader.sv
// Captures the leading digest lanes of each Keccak-f result into a small FIFO and
// streams them out one 64-bit word per handshake, flagging states dropped on overflow.
module sha3_digest_unloader #(
    parameter int unsigned DIGEST_LANES = 4,
    parameter int unsigned DEPTH        = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [4:0][63:0]             isa,
    input  logic [4:0][63:0]             isb,
    input  logic [4:0][63:0]             isc,
    input  logic [4:0][63:0]             isd,
    input  logic [4:0][63:0]             ise,
    input  logic                         sample,
    output logic [63:0]                  odata,
    output logic                         ovalid,
    output logic                         olast,
    input  logic                         iready,
    output logic [$clog2(DEPTH+1)-1:0]   ocount,
    output logic                         overflow
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned WcW  = (DIGEST_LANES > 1) ? $clog2(DIGEST_LANES) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    localparam logic [PtrW-1:0] PtrLast = PtrW'(DEPTH - 1);
    localparam logic [WcW-1:0]  WcLast  = WcW'(DIGEST_LANES - 1);
    localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);

    // Lane k sits at index k: row a holds lanes 0..4, row e holds lanes 20..24.
    logic [24:0][63:0] lanes;
    assign lanes = {ise, isd, isc, isb, isa};

    logic [DIGEST_LANES-1:0][63:0] store_q [DEPTH];

    logic [PtrW-1:0] wp_q, wp_d;
    logic [PtrW-1:0] rp_q, rp_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [WcW-1:0]  wc_q, wc_d;
    logic            overflow_q, overflow_d;

    logic valid_c;
    logic pop;
    logic pop_last;
    logic space;
    logic push;

    always_comb begin
        valid_c  = (cnt_q != '0);
        pop      = valid_c & iready;
        pop_last = pop & (wc_q == WcLast);
        // A full FIFO still has room when the head digest retires on this edge.
        space    = (cnt_q != CntFull) | pop_last;
        push     = sample & space;

        wp_d       = wp_q;
        rp_d       = rp_q;
        cnt_d      = cnt_q;
        wc_d       = wc_q;
        overflow_d = overflow_q | (sample & ~space);

        if (push) begin
            wp_d = (wp_q == PtrLast) ? '0 : wp_q + PtrW'(1);
        end

        if (pop) begin
            if (pop_last) begin
                wc_d = '0;
                rp_d = (rp_q == PtrLast) ? '0 : rp_q + PtrW'(1);
            end else begin
                wc_d = wc_q + WcW'(1);
            end
        end

        case ({push, pop_last})
            2'b10:   cnt_d = cnt_q + CntW'(1);
            2'b01:   cnt_d = cnt_q - CntW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp_q       <= '0;
            rp_q       <= '0;
            cnt_q      <= '0;
            wc_q       <= '0;
            overflow_q <= 1'b0;
        end else begin
            wp_q       <= wp_d;
            rp_q       <= rp_d;
            cnt_q      <= cnt_d;
            wc_q       <= wc_d;
            overflow_q <= overflow_d;
        end
    end

    // Payload storage carries no reset; the output mux below hides any stale entry.
    always_ff @(posedge clk) begin
        if (push) begin
            store_q[wp_q] <= lanes[DIGEST_LANES-1:0];
        end
    end

    always_comb begin
        ovalid   = valid_c;
        olast    = valid_c & (wc_q == WcLast);
        odata    = valid_c ? store_q[rp_q][wc_q] : '0;
        ocount   = cnt_q;
        overflow = overflow_q;
    end

endmodule

// File: tb/tb_sha3_digest_unloader.sv
// Randomized bench for sha3_digest_unloader: a 4-lane/4-deep and an 8-lane/3-deep instance
// are compared every cycle against a word-queue reference model.
module tb_sha3_digest_unloader;

    logic            clk;
    logic            rst;
    logic [4:0][63:0] isa, isb, isc, isd, ise;
    logic            sample_v   [2];
    logic            iready_v   [2];
    logic [63:0]     odata_v    [2];
    logic            ovalid_v   [2];
    logic            olast_v    [2];
    logic            overflow_v [2];
    logic [2:0]      ocount_a;
    logic [1:0]      ocount_b;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: per instance a queue of {last, word} plus the digest count.
    logic [64:0] wq   [2][$];
    int          dcnt [2];
    bit          ovf  [2];
    bit          m_pop, m_pl, m_sp;

    sha3_digest_unloader #(.DIGEST_LANES(4), .DEPTH(4)) u_a (
        .clk(clk), .rst(rst), .isa(isa), .isb(isb), .isc(isc), .isd(isd), .ise(ise),
        .sample(sample_v[0]), .odata(odata_v[0]), .ovalid(ovalid_v[0]), .olast(olast_v[0]),
        .iready(iready_v[0]), .ocount(ocount_a), .overflow(overflow_v[0])
    );

    sha3_digest_unloader #(.DIGEST_LANES(8), .DEPTH(3)) u_b (
        .clk(clk), .rst(rst), .isa(isa), .isb(isb), .isc(isc), .isd(isd), .ise(ise),
        .sample(sample_v[1]), .odata(odata_v[1]), .ovalid(ovalid_v[1]), .olast(olast_v[1]),
        .iready(iready_v[1]), .ocount(ocount_b), .overflow(overflow_v[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int dl(int i);
        return (i == 0) ? 4 : 8;
    endfunction

    function automatic int dp(int i);
        return (i == 0) ? 4 : 3;
    endfunction

    function automatic logic [63:0] get_lane(int k);
        case (k / 5)
            0:       return isa[k % 5];
            1:       return isb[k % 5];
            2:       return isc[k % 5];
            3:       return isd[k % 5];
            default: return ise[k % 5];
        endcase
    endfunction

    function automatic int ocnt(int i);
        return (i == 0) ? int'(ocount_a) : int'(ocount_b);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                wq[i].delete();
                dcnt[i] = 0;
                ovf[i]  = 1'b0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                m_pop = (wq[i].size() != 0) && iready_v[i];
                m_pl  = m_pop && wq[i][0][64];
                m_sp  = (dcnt[i] < dp(i)) || m_pl;
                if (m_pop) begin
                    void'(wq[i].pop_front());
                    if (m_pl) dcnt[i]--;
                end
                if (sample_v[i]) begin
                    if (m_sp) begin
                        for (int k = 0; k < dl(i); k++) begin
                            wq[i].push_back({(k == dl(i) - 1), get_lane(k)});
                        end
                        dcnt[i]++;
                    end else begin
                        ovf[i] = 1'b1;
                    end
                end
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("u%0d_ovalid", i), 64'(ovalid_v[i]), 64'(wq[i].size() != 0));
            check($sformatf("u%0d_olast", i), 64'(olast_v[i]),
                  64'((wq[i].size() != 0) && wq[i][0][64]));
            if (wq[i].size() != 0) begin
                check($sformatf("u%0d_odata", i), odata_v[i], wq[i][0][63:0]);
            end
            check($sformatf("u%0d_ocount", i), 64'(ocnt(i)), 64'(dcnt[i]));
            check($sformatf("u%0d_overflow", i), 64'(overflow_v[i]), 64'(ovf[i]));
        end
    endtask

    task automatic rand_lanes();
        for (int c = 0; c < 5; c++) begin
            isa[c] = {$urandom, $urandom};
            isb[c] = {$urandom, $urandom};
            isc[c] = {$urandom, $urandom};
            isd[c] = {$urandom, $urandom};
            ise[c] = {$urandom, $urandom};
        end
    endtask

    initial begin
        logic [63:0] lane0;
        int          issued;
        int          cyc;

        rst = 1'b1;
        isa = '0; isb = '0; isc = '0; isd = '0; ise = '0;
        for (int i = 0; i < 2; i++) begin
            sample_v[i] = 1'b0;
            iready_v[i] = 1'b0;
        end
        tick();
        tick();
        check("rst_odata", odata_v[0], 64'h0);
        check("rst_ocount", 64'(ocount_a), 64'h0);
        rst = 1'b0;

        // Single digest, lanes 0..3 = 0..3, downstream always ready.
        for (int c = 0; c < 5; c++) isa[c] = 64'(c);
        sample_v[0] = 1'b1;
        iready_v[0] = 1'b1;
        tick();
        sample_v[0] = 1'b0;
        check("t1_ocount_first", 64'(ocount_a), 64'd1);
        for (int w = 0; w < 4; w++) begin
            check("t1_ovalid", 64'(ovalid_v[0]), 64'd1);
            check("t1_odata", odata_v[0], 64'(w));
            check("t1_olast", 64'(olast_v[0]), 64'(w == 3));
            tick();
        end
        check("t1_ocount_end", 64'(ocount_a), 64'd0);

        // Backpressure: hold, then toggle ready.
        rand_lanes();
        lane0 = get_lane(0);
        sample_v[0] = 1'b1;
        iready_v[0] = 1'b0;
        tick();
        sample_v[0] = 1'b0;
        for (int t = 0; t < 5; t++) begin
            check("bp_hold_data", odata_v[0], lane0);
            check("bp_hold_valid", 64'(ovalid_v[0]), 64'd1);
            tick();
        end
        for (int t = 0; t < 8; t++) begin
            iready_v[0] = (t % 2 == 0);
            tick();
        end
        iready_v[0] = 1'b1;
        repeat (6) tick();

        // Fill then overflow with iready low; drain the four kept digests.
        iready_v[0] = 1'b0;
        for (int s = 0; s < 5; s++) begin
            rand_lanes();
            sample_v[0] = 1'b1;
            tick();
        end
        sample_v[0] = 1'b0;
        check("fill_ocount", 64'(ocount_a), 64'd4);
        check("fill_overflow", 64'(overflow_v[0]), 64'd1);
        iready_v[0] = 1'b1;
        for (int w = 0; w < 16; w++) begin
            check("drain_valid", 64'(ovalid_v[0]), 64'd1);
            check("drain_olast", 64'(olast_v[0]), 64'(w % 4 == 3));
            tick();
        end
        check("drain_empty", 64'(ovalid_v[0]), 64'd0);
        check("drain_ovf_sticky", 64'(overflow_v[0]), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;

        // Full FIFO: sample lands on the edge that retires the head's last word.
        iready_v[0] = 1'b0;
        for (int s = 0; s < 4; s++) begin
            rand_lanes();
            sample_v[0] = 1'b1;
            tick();
        end
        sample_v[0] = 1'b0;
        iready_v[0] = 1'b1;
        repeat (3) tick();
        check("sim_olast", 64'(olast_v[0]), 64'd1);
        check("sim_full", 64'(ocount_a), 64'd4);
        rand_lanes();
        sample_v[0] = 1'b1;
        tick();
        sample_v[0] = 1'b0;
        check("sim_no_ovf", 64'(overflow_v[0]), 64'd0);
        check("sim_ocount", 64'(ocount_a), 64'd4);
        repeat (20) tick();
        iready_v[0] = 1'b0;

        // SHA3-512 lane order: isa[0..4] then isb[0..2].
        for (int c = 0; c < 5; c++) begin
            isa[c] = 64'(100 + c);
            isb[c] = 64'(105 + c);
        end
        sample_v[1] = 1'b1;
        iready_v[1] = 1'b1;
        tick();
        sample_v[1] = 1'b0;
        for (int w = 0; w < 8; w++) begin
            check("s512_odata", odata_v[1], 64'(100 + w));
            check("s512_olast", 64'(olast_v[1]), 64'(w == 7));
            tick();
        end

        // Wrap-around on the 3-deep instance with random gaps and ready.
        issued = 0;
        cyc = 0;
        while ((issued < 10 || wq[1].size() != 0) && cyc < 3000) begin
            iready_v[1] = 1'($urandom % 2);
            if (issued < 10 && dcnt[1] < 3 && ($urandom % 3) == 0) begin
                rand_lanes();
                sample_v[1] = 1'b1;
                issued++;
            end else begin
                sample_v[1] = 1'b0;
            end
            tick();
            check("wrap_ocount_max", 64'(ocount_b <= 2'd3), 64'd1);
            cyc++;
        end
        sample_v[1] = 1'b0;
        iready_v[1] = 1'b0;
        check("wrap_done", 64'(issued == 10 && wq[1].size() == 0), 64'd1);

        // Asynchronous reset after lane 1 has been accepted.
        rand_lanes();
        sample_v[0] = 1'b1;
        tick();
        sample_v[0] = 1'b0;
        iready_v[0] = 1'b1;
        tick();
        tick();
        #2 rst = 1'b1;
        #1;
        check("mrst_ovalid", 64'(ovalid_v[0]), 64'd0);
        check("mrst_olast", 64'(olast_v[0]), 64'd0);
        check("mrst_odata", odata_v[0], 64'h0);
        check("mrst_ocount", 64'(ocount_a), 64'd0);
        iready_v[0] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        rand_lanes();
        lane0 = get_lane(0);
        sample_v[0] = 1'b1;
        tick();
        sample_v[0] = 1'b0;
        check("mrst_next_ocount", 64'(ocount_a), 64'd1);
        check("mrst_next_lane0", odata_v[0], lane0);
        iready_v[0] = 1'b1;
        repeat (6) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
